// File: rtl/mem_access_unit_if.sv
// Memory bus between the load/store unit and the data memory port.
// The unit owns the request side (master); the memory owns the
// handshake acknowledgements and read data (slave).
interface mem_access_unit_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic            mem_req;
    logic            mem_wr;
    logic [1:0]      mem_size;
    logic [AW-1:0]   mem_addr;
    logic [DW/8-1:0] mem_wstrb;
    logic [DW-1:0]   mem_wdata;
    logic            mem_addr_ok;
    logic            mem_data_ok;
    logic [DW-1:0]   mem_rdata;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_size,
        output mem_addr,
        output mem_wstrb,
        output mem_wdata,
        input  mem_addr_ok,
        input  mem_data_ok,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_size,
        input  mem_addr,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_addr_ok,
        output mem_data_ok,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage memory access unit: checks alignment, runs one split
// address/data bus transaction at a time, aligns and extends load data,
// and holds the pipeline until the response is ready to be consumed.
module mem_access_unit #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signext,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    input  logic              pipe_ready,
    input  logic              flush,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              adel,
    output logic              ades,
    mem_access_unit_if.master bus
);
    localparam int SW   = DW / 8;
    localparam int OFFW = $clog2(SW);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DONE,
        DRAIN
    } state_t;

    // Byte-lane strobe for an access of 2^size bytes starting at lane off.
    function automatic logic [SW-1:0] lane_strobe(input logic [1:0] size,
                                                  input logic [OFFW-1:0] off);
        logic [SW-1:0] base;
        case (size)
            2'd0:    base = SW'(1);
            2'd1:    base = SW'(3);
            2'd2:    base = SW'(15);
            default: base = '1;
        endcase
        return base << off;
    endfunction

    // Truncate right-justified load data to the access size, then sign- or
    // zero-extend it back to the full data width.
    function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] raw,
                                                  input logic [1:0]    size,
                                                  input logic          sext);
        logic signed [DW-1:0] ext;
        ext = '0;
        case (size)
            2'd0: begin
                if (sext) ext = DW'($signed(raw[7:0]));
                else      ext = DW'(raw[7:0]);
            end
            2'd1: begin
                if (sext) ext = DW'($signed(raw[15:0]));
                else      ext = DW'(raw[15:0]);
            end
            2'd2: begin
                if (sext) ext = DW'($signed(raw[31:0]));
                else      ext = DW'(raw[31:0]);
            end
            default: ext = raw;
        endcase
        return ext;
    endfunction

    state_t          state_q, state_d;
    logic            wr_q, wr_d;
    logic [1:0]      size_q, size_d;
    logic            sext_q, sext_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic [OFFW-1:0] req_off;
    logic [OFFW-1:0] lat_off;
    logic            misaligned;
    logic            illegal;
    logic            accept;
    logic            in_addr;

    assign req_off = req_addr[OFFW-1:0];
    assign lat_off = addr_q[OFFW-1:0];
    assign in_addr = (state_q == ADDR);

    // Alignment and size legality of the incoming pipeline request.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_off[0];
            2'd2:    misaligned = |req_off[1:0];
            default: misaligned = |req_off;
        endcase
        illegal = (req_size == 2'd3) && (DW == 32);
    end

    // Next-state, field latching and load-data capture.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        size_d      = size_q;
        sext_d      = sext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        accept      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && !flush && !misaligned && !illegal) begin
                    accept  = 1'b1;
                    wr_d    = req_write;
                    size_d  = req_size;
                    sext_d  = req_signext;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // An addr_ok together with flush means the memory already took
                // the request, so its data phase still has to be drained.
                // A data_ok in this state is never the answer to this request.
                if (flush)                state_d = bus.mem_addr_ok ? DRAIN : IDLE;
                else if (bus.mem_addr_ok) state_d = DATA;
            end
            DATA: begin
                if (bus.mem_data_ok) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        rsp_rdata_d = wr_q ? '0
                                           : load_extend(bus.mem_rdata >> {lat_off, 3'b000},
                                                         size_q, sext_q);
                        state_d     = DONE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (flush || pipe_ready) state_d = IDLE;
            end
            DRAIN: begin
                if (bus.mem_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == DONE);
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            size_q      <= 2'd0;
            sext_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Pipeline-side status; the accept/error terms are combinational so the
    // M stage sees them in the same cycle the request is presented.
    always_comb begin
        stall = !rst && (accept || (state_q == ADDR) || (state_q == DATA) ||
                         (state_q == DRAIN));
        adel  = !rst && (state_q == IDLE) && req_valid && !flush &&
                (misaligned || illegal) && !req_write;
        ades  = !rst && (state_q == IDLE) && req_valid && !flush &&
                (misaligned || illegal) && req_write;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    // Bus request is presented only while in ADDR and is zero everywhere else.
    always_comb begin
        bus.mem_req   = in_addr;
        bus.mem_wr    = in_addr && wr_q;
        bus.mem_size  = in_addr ? size_q : 2'd0;
        bus.mem_addr  = in_addr ? addr_q : '0;
        bus.mem_wstrb = (in_addr && wr_q) ? lane_strobe(size_q, lat_off) : '0;
        bus.mem_wdata = in_addr ? (wdata_q << {lat_off, 3'b000}) : '0;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: one DW=32 and one DW=64 instance share the
// stimulus, with sel choosing which one is active.
module tb_mem_access_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req_valid, req_write, req_signext, pipe_ready, flush;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        addr_ok, data_ok;
    logic [63:0] rdata;

    int checks   = 0;
    int failures = 0;

    mem_access_unit_if #(.DW(32), .AW(32)) bus32 ();
    mem_access_unit_if #(.DW(64), .AW(32)) bus64 ();

    assign bus32.mem_addr_ok = addr_ok & ~sel;
    assign bus32.mem_data_ok = data_ok & ~sel;
    assign bus32.mem_rdata   = rdata[31:0];
    assign bus64.mem_addr_ok = addr_ok & sel;
    assign bus64.mem_data_ok = data_ok & sel;
    assign bus64.mem_rdata   = rdata;

    logic        st32, rv32, adel32, ades32;
    logic [31:0] rd32;
    logic        st64, rv64, adel64, ades64;
    logic [63:0] rd64;

    mem_access_unit #(.DW(32), .AW(32)) u32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_write(req_write), .req_size(req_size),
        .req_signext(req_signext), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .pipe_ready(pipe_ready), .flush(flush & ~sel),
        .stall(st32), .rsp_valid(rv32), .rsp_rdata(rd32), .adel(adel32), .ades(ades32),
        .bus(bus32.master)
    );

    mem_access_unit #(.DW(64), .AW(32)) u64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_write(req_write), .req_size(req_size),
        .req_signext(req_signext), .req_addr(req_addr), .req_wdata(req_wdata),
        .pipe_ready(pipe_ready), .flush(flush & sel),
        .stall(st64), .rsp_valid(rv64), .rsp_rdata(rd64), .adel(adel64), .ades(ades64),
        .bus(bus64.master)
    );

    // Observed view of whichever instance is selected.
    logic        o_stall, o_rv, o_adel, o_ades, o_mreq, o_mwr;
    logic [1:0]  o_msize;
    logic [31:0] o_maddr;
    logic [7:0]  o_mstrb;
    logic [63:0] o_mwdata, o_rd;
    assign o_stall  = sel ? st64 : st32;
    assign o_rv     = sel ? rv64 : rv32;
    assign o_adel   = sel ? adel64 : adel32;
    assign o_ades   = sel ? ades64 : ades32;
    assign o_rd     = sel ? rd64 : {32'd0, rd32};
    assign o_mreq   = sel ? bus64.mem_req : bus32.mem_req;
    assign o_mwr    = sel ? bus64.mem_wr : bus32.mem_wr;
    assign o_msize  = sel ? bus64.mem_size : bus32.mem_size;
    assign o_maddr  = sel ? bus64.mem_addr : bus32.mem_addr;
    assign o_mstrb  = sel ? bus64.mem_wstrb : {4'd0, bus32.mem_wstrb};
    assign o_mwdata = sel ? bus64.mem_wdata : {32'd0, bus32.mem_wdata};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Reference model: byte-level view of the access rules.
    function automatic bit ref_bad(int dw, logic [1:0] size, logic [31:0] addr);
        int off = int'(addr % (dw / 8));
        return ((off % (1 << size)) != 0) || (size == 2'd3 && dw == 32);
    endfunction

    function automatic logic [7:0] ref_strb(int dw, bit wr, logic [1:0] size, logic [31:0] addr);
        logic [7:0] s = '0;
        int off = int'(addr % (dw / 8));
        if (wr) for (int i = 0; i < (1 << size); i++) s[off + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] ref_wbus(int dw, logic [31:0] addr, logic [63:0] wd);
        logic [63:0] w = '0;
        int nb  = dw / 8;
        int off = int'(addr % nb);
        for (int j = off; j < nb; j++) w[8*j +: 8] = wd[8*(j-off) +: 8];
        return w;
    endfunction

    function automatic logic [63:0] ref_load(int dw, bit wr, logic [1:0] size, bit sext,
                                             logic [31:0] addr, logic [63:0] rd);
        logic [63:0] v = '0;
        int nb  = dw / 8;
        int n   = 1 << size;
        int off = int'(addr % nb);
        if (wr) return '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (sext && v[8*n-1]) for (int i = n; i < nb; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // One complete request with chosen handshake latencies. Starts and ends
    // one time unit after a rising edge.
    task automatic txn(input bit s, input bit wr, input logic [1:0] size, input bit sext,
                       input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       input int alat, input int dlat, input int hold, input bit dual,
                       output int stalls, output logic [7:0] strb_seen,
                       output logic [63:0] wbus_seen, output logic [63:0] rd_seen);
        int dw = s ? 64 : 32;
        logic [63:0] exp_rd;
        sel = s; stalls = 0; strb_seen = '0; wbus_seen = '0; rd_seen = '0;
        req_valid = 1'b1; req_write = wr; req_size = size; req_signext = sext;
        req_addr = addr; req_wdata = wd; pipe_ready = 1'b0;
        look();
        if (ref_bad(dw, size, addr)) begin
            check("err_adel", o_adel, !wr);
            check("err_ades", o_ades, wr);
            check("err_stall", o_stall, 0);
            check("err_mreq", o_mreq, 0);
            go(); req_valid = 1'b0;
            look();
            check("err_mreq_next", o_mreq, 0);
            check("err_stall_next", o_stall, 0);
            go();
            return;
        end
        check("acc_stall", o_stall, 1);
        check("acc_err", {o_adel, o_ades}, 0);
        check("acc_rv", o_rv, 0);
        stalls++;
        go();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = {$urandom, $urandom};
        req_size = 2'($urandom); req_write = 1'($urandom);
        for (int i = 0; i <= alat; i++) begin
            addr_ok = (i == alat);
            data_ok = (i == alat) && dual;
            look();
            if (o_stall) stalls++;
            if (i == 0) begin strb_seen = o_mstrb; wbus_seen = o_mwdata; end
            check("addr_mreq", o_mreq, 1);
            check("addr_mwr", o_mwr, wr);
            check("addr_msize", o_msize, size);
            check("addr_maddr", o_maddr, addr);
            check("addr_wstrb", o_mstrb, ref_strb(dw, wr, size, addr));
            check("addr_wdata", o_mwdata, ref_wbus(dw, addr, wd));
            go();
        end
        addr_ok = 1'b0; data_ok = 1'b0;
        for (int i = 0; i <= dlat; i++) begin
            data_ok = (i == dlat);
            rdata   = (i == dlat) ? rd : {$urandom, $urandom};
            look();
            if (o_stall) stalls++;
            check("data_bus_idle", {o_mreq, o_mstrb, o_maddr}, 0);
            check("data_rv", o_rv, 0);
            go();
        end
        data_ok = 1'b0;
        exp_rd = ref_load(dw, wr, size, sext, addr, rd);
        for (int i = 0; i <= hold; i++) begin
            pipe_ready = (i == hold);
            req_valid  = 1'($urandom);
            look();
            if (i == 0) rd_seen = o_rd;
            check("done_rv", o_rv, 1);
            check("done_stall", o_stall, 0);
            check("done_rdata", o_rd, exp_rd);
            check("done_bus_idle", o_mreq, 0);
            go();
        end
        pipe_ready = 1'b0; req_valid = 1'b0;
        look();
        check("back_idle_rv", o_rv, 0);
        check("back_idle_stall", o_stall, 0);
        check("stall_cycles", stalls, alat + dlat + 3);
        go();
    endtask

    // Present a legal request and leave the unit in ADDR.
    task automatic start(input bit s, input bit wr, input logic [1:0] size, input logic [31:0] addr);
        sel = s; req_valid = 1'b1; req_write = wr; req_size = size; req_signext = 1'b0;
        req_addr = addr; req_wdata = {$urandom, $urandom};
        look();
        check("start_stall", o_stall, 1);
        go();
        req_valid = 1'b0;
    endtask

    initial begin
        int          st;
        logic [7:0]  sb;
        logic [63:0] wb, rb;
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signext = 1'b0; req_addr = '0; req_wdata = '0; pipe_ready = 1'b0; flush = 1'b0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;

        repeat (2) look();
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            check("rst_outputs", {o_stall, o_rv, o_adel, o_ades, o_mreq, o_mwr, o_msize}, 0);
            check("rst_bus", {o_maddr, o_mstrb, o_mwdata[31:0]}, 0);
            check("rst_rdata", o_rd, 0);
        end
        go(); rst = 1'b0; sel = 1'b0;
        go();

        // lb at 0x1003 with sign extension
        txn(0, 0, 2'd0, 1, 32'h1003, 64'd0, 64'h80FF_1234, 0, 1, 0, 0, st, sb, wb, rb);
        check("case1_rdata", rb, 64'hFFFF_FF80);
        check("case1_stall_cycles", st, 4);

        // sh at 0x2002
        txn(0, 1, 2'd1, 0, 32'h2002, 64'h0000_ABCD, 64'd0, 0, 0, 0, 0, st, sb, wb, rb);
        check("case2_wstrb", sb, 8'b1100);
        check("case2_wdata", wb, 64'hABCD_0000);
        check("case2_store_rdata", rb, 0);

        // misaligned lw
        txn(0, 0, 2'd2, 0, 32'h3001, 64'd0, 64'd0, 0, 0, 0, 0, st, sb, wb, rb);
        // dword load on a 32-bit unit is illegal
        txn(0, 0, 2'd3, 0, 32'h0000_0010, 64'd0, 64'd0, 0, 0, 0, 0, st, sb, wb, rb);

        // ld at 0x8 on the 64-bit unit
        txn(1, 0, 2'd3, 0, 32'h8, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 0, 1, 0, st, sb, wb, rb);
        check("case4_rdata", rb, 64'h0123_4567_89AB_CDEF);
        check("case4_wstrb", sb, 0);

        // Flush in DATA, data arrives three cycles later and is discarded
        start(0, 0, 2'd2, 32'h100);
        addr_ok = 1'b1; go(); addr_ok = 1'b0;
        flush = 1'b1; look(); check("c5_data_stall", o_stall, 1); go(); flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_ok = (i == 2); rdata = {$urandom, $urandom};
            look();
            check("c5_drain_stall", o_stall, 1);
            check("c5_drain_rv_mreq", {o_rv, o_mreq}, 0);
            go();
        end
        data_ok = 1'b0;
        txn(0, 0, 2'd1, 1, 32'h0000_0206, 64'd0, 64'h0000_8001_0000_0000, 0, 0, 0, 0, st, sb, wb, rb);

        // Flush in ADDR without addr_ok returns straight to IDLE
        start(1, 1, 2'd2, 32'h44);
        flush = 1'b1; look(); check("fa_mreq", o_mreq, 1); go(); flush = 1'b0;
        look(); check("fa_idle", {o_stall, o_mreq, o_rv}, 0); go();

        // Flush in ADDR with addr_ok must drain the data phase
        start(0, 0, 2'd0, 32'h45);
        flush = 1'b1; addr_ok = 1'b1; go(); flush = 1'b0; addr_ok = 1'b0;
        look(); check("fd_drain_stall", o_stall, 1); check("fd_drain_mreq", o_mreq, 0);
        data_ok = 1'b1; go(); data_ok = 1'b0;
        look(); check("fd_idle", {o_stall, o_rv}, 0); go();

        // Flush in DATA coinciding with data_ok goes straight to IDLE
        start(0, 0, 2'd2, 32'h48);
        addr_ok = 1'b1; go(); addr_ok = 1'b0;
        flush = 1'b1; data_ok = 1'b1; go(); flush = 1'b0; data_ok = 1'b0;
        look(); check("fdd_idle", {o_stall, o_rv}, 0); go();

        // Flush in DONE drops the response
        start(1, 0, 2'd1, 32'h4A);
        addr_ok = 1'b1; go(); addr_ok = 1'b0;
        data_ok = 1'b1; go(); data_ok = 1'b0;
        look(); check("fdone_rv", o_rv, 1);
        flush = 1'b1; go(); flush = 1'b0;
        look(); check("fdone_cleared", {o_rv, o_stall}, 0); go();

        // Flush in IDLE suppresses both the error and the acceptance
        sel = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h3001;
        flush = 1'b1;
        look(); check("fidle_err", {o_adel, o_ades, o_stall}, 0);
        req_write = 1'b1; req_addr = 32'h3000;
        look(); check("fidle_acc", {o_adel, o_ades, o_stall}, 0);
        go(); req_valid = 1'b0; flush = 1'b0;
        look(); check("fidle_no_bus", {o_mreq, o_stall}, 0); go();

        // Reset pulsed while in DATA; a late data_ok must not produce a response
        start(0, 0, 2'd2, 32'h80);
        addr_ok = 1'b1; go(); addr_ok = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("c6_rst_ctrl", {o_stall, o_rv, o_adel, o_ades, o_mreq, o_mwr, o_msize}, 0);
        check("c6_rst_bus", {o_maddr, o_mstrb, o_mwdata[31:0]}, 0);
        go(); rst = 1'b0;
        data_ok = 1'b1; rdata = {$urandom, $urandom}; go(); data_ok = 1'b0;
        look(); check("c6_stale_rv", {o_rv, o_stall, o_mreq}, 0); go();
        txn(0, 0, 2'd2, 0, 32'h0000_0C00, 64'd0, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, 0, st, sb, wb, rb);
        check("c6_recover", rb, 64'hDEAD_BEEF);

        // Randomized traffic across both widths
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            txn(1'($urandom), 1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom},
                {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), 1'($urandom), st, sb, wb, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter AW, default 32, meaning address width in bits.
REQ-003 SHALL have ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-004 SHALL have pipeline-side inputs:
- req_valid 1, M-stage memory op present.
- req_write 1, store=1 / load=0.
- req_size 2, 00 byte, 01 half, 10 word, 11 dword.
- req_signext 1, sign-extend load data.
- req_addr AW; req_wdata DW.
- pipe_ready 1, M stage may advance.
- flush 1, cancel current op.
REQ-005 SHALL have pipeline-side outputs:
- stall 1.
- rsp_valid 1.
- rsp_rdata DW.
- adel 1, load address error.
- ades 1, store address error.
REQ-006 SHALL have bus outputs:
- mem_req 1; mem_wr 1; mem_size 2.
- mem_addr AW.
- mem_wstrb DW/8.
- mem_wdata DW.
REQ-007 SHALL have bus inputs: mem_addr_ok 1, mem_data_ok 1, mem_rdata DW.

Function
REQ-008 SHALL implement states IDLE, ADDR, DATA, DONE, DRAIN.
REQ-009 Legality:
- off = req_addr[log2(DW/8)-1:0].
- A request is misaligned when off is not a multiple of 2^req_size.
- A request is illegal when req_size=11 and DW=32.
REQ-010 In IDLE with req_valid=1, flush=0 and the request misaligned or illegal:
- adel=!req_write or ades=req_write, combinationally.
- stall=0; no bus transaction; state stays IDLE.
REQ-011 In IDLE with req_valid=1, flush=0 and the request legal:
- stall=1 combinationally.
- Latch write, size, signext, addr and wdata.
- Go to ADDR next cycle.
REQ-012 In ADDR:
- mem_req=1; bus outputs driven from the latched values.
- mem_addr=latched addr.
- mem_wstrb=(2^(2^size)-1)<<off when write, else 0.
- mem_wdata=latched wdata shifted left by off*8.
- On mem_addr_ok go to DATA.
REQ-013 In DATA, mem_req=0; on mem_data_ok:
- Capture rsp_rdata = mem_rdata>>(off*8), truncated to the access size.
- Extend to DW with the bit at position 2^size*8-1 when signext=1; zero-extend otherwise; stores capture 0.
- Go to DONE.
REQ-014 mem_addr_ok and mem_data_ok in the same cycle while in ADDR SHALL be treated as addr_ok only; data_ok is not expected before the cycle after addr_ok.
REQ-015 In DONE:
- rsp_valid=1, stall=0, rsp_rdata held.
- req_valid ignored.
- Return to IDLE when pipe_ready=1.
REQ-016 Stall rule: stall=1 in ADDR, DATA and DRAIN; stall=0 in DONE and in IDLE except per REQ-011.
REQ-017 flush in IDLE SHALL suppress adel/ades and acceptance.
REQ-018 flush in ADDR:
- Return to IDLE next cycle if mem_addr_ok=0 that cycle.
- Otherwise go to DRAIN.
REQ-019 flush in DATA SHALL go to DRAIN, or to IDLE if mem_data_ok=1 that cycle; the data is discarded.
REQ-020 flush in DONE SHALL go to IDLE and clear rsp_valid next cycle.
REQ-021 DRAIN SHALL assert mem_req=0, wait for mem_data_ok, discard the data, then go to IDLE; rsp_valid stays 0.
REQ-022 At most one outstanding bus transaction SHALL exist at any time.
REQ-023 Bus outputs SHALL be 0 in every state other than ADDR.

Reset
REQ-024 rst=1 SHALL asynchronously force:
- state IDLE.
- All latched fields and rsp_rdata to 0.
- stall, rsp_valid, adel, ades, mem_req, mem_wr, mem_wstrb, mem_wdata, mem_addr, mem_size to 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction; a mem_data_ok arriving after reset release while in IDLE SHALL be ignored.

Verification
REQ-026 Case 1 (DW=32, byte load): lb at addr 0x1003, signext=1, mem_rdata=0x80FF_1234, addr_ok after 1 cycle, data_ok after 2 -> rsp_rdata=0xFFFF_FF80; stall high for 4 cycles.
REQ-027 Case 2 (DW=32, half store): sh at addr 0x2002, wdata=0x0000_ABCD -> mem_wstrb=1100, mem_wdata=0xABCD_0000, mem_wr=1.
REQ-028 Case 3 (DW=32, misaligned load): lw at addr 0x3001 -> adel=1 same cycle, stall=0, mem_req never asserted.
REQ-029 Case 4 (DW=64, dword load): ld at addr 0x8, mem_rdata=0x0123_4567_89AB_CDEF -> rsp_rdata identical, mem_wstrb=0.
REQ-030 Case 5 (flush after addr_ok): flush while in DATA, data_ok 3 cycles later -> rsp_valid stays 0; state IDLE the cycle after data_ok; next request accepted normally.
REQ-031 Case 6 (reset mid-op): rst pulsed while in DATA -> all outputs 0 immediately; a stale data_ok produces no rsp_valid.
